phase_sweep_ctrl: RTL

Synchronous sequencer that drives the phase codes of a lead/lag differential clock pair. It sweeps the differential phase code over a programmed number of points around a fixed common-mode code, holding each point for a settle interval and a dwell interval. It pulses a measurement strobe at the end of each dwell and signals completion. It sits between a test/calibration master and the phase-to-clock stimulus, which turns `lead_code`/`lag_code` into clock delays (code 2^N_PH = 2π).

---
 rtl/phase_sweep_pkg.sv | 30 +++
 rtl/phase_sweep_if.sv | 33 +++
 rtl/phase_sweep_ctrl_pair_map.sv | 42 ++++
 rtl/phase_sweep_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/phase_sweep_pkg.sv
// Shared types and code arithmetic for the phase sweep controller.
// Lead/lag mapping is width-agnostic; callers truncate to their code width.
package phase_sweep_pkg;

    localparam int PH_CALC_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DWELL,
        FINISH
    } state_e;

    typedef struct packed {
        logic [PH_CALC_W-1:0] lead;
        logic [PH_CALC_W-1:0] lag;
    } ph_pair_t;

    // diff must arrive zero-extended so the shift is logical within the code width
    function automatic ph_pair_t ph_pair(
        input logic [PH_CALC_W-1:0] cm,
        input logic [PH_CALC_W-1:0] diff
    );
        ph_pair_t p;
        p.lead = cm - (diff >> 1);
        p.lag  = p.lead + diff;
        return p;
    endfunction

endpackage

// File: rtl/phase_sweep_if.sv
// Control/config/status bundle between a calibration master
// and the phase sweep controller.
interface phase_sweep_if #(
    parameter int N_PH  = 7,
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic [N_PH-1:0]  cm_code;
    logic [N_PH-1:0]  diff_start;
    logic [N_PH-1:0]  diff_step;
    logic [CNT_W-1:0] n_pts;
    logic [CNT_W-1:0] settle;
    logic [CNT_W-1:0] dwell;
    logic [N_PH-1:0]  lead_code;
    logic [N_PH-1:0]  lag_code;
    logic             busy;
    logic             meas_stb;
    logic [CNT_W-1:0] pt_idx;
    logic             done;

    modport master (
        output start, abort, cm_code, diff_start, diff_step,
        output n_pts, settle, dwell,
        input  lead_code, lag_code, busy, meas_stb, pt_idx, done
    );

    modport slave (
        input  start, abort, cm_code, diff_start, diff_step,
        input  n_pts, settle, dwell,
        output lead_code, lag_code, busy, meas_stb, pt_idx, done
    );
endinterface

// File: rtl/phase_sweep_ctrl_pair_map.sv
// Registered (cm, diff) -> (lead, lag) code conversion; lag - lead == diff.
// Loads only when en is high, otherwise holds the last pair.
module phase_pair_map
    import phase_sweep_pkg::*;
#(
    parameter int N_PH = 7
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            en,
    input  logic [N_PH-1:0] cm,
    input  logic [N_PH-1:0] diff,
    output logic [N_PH-1:0] lead,
    output logic [N_PH-1:0] lag
);
    logic [N_PH-1:0] lead_q, lead_d;
    logic [N_PH-1:0] lag_q, lag_d;
    ph_pair_t        pair;

    always_comb begin
        pair   = ph_pair(PH_CALC_W'(cm), PH_CALC_W'(diff));
        lead_d = lead_q;
        lag_d  = lag_q;
        if (en) begin
            lead_d = N_PH'(pair.lead);
            lag_d  = N_PH'(pair.lag);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lead_q <= '0;
            lag_q  <= '0;
        end else begin
            lead_q <= lead_d;
            lag_q  <= lag_d;
        end
    end

    assign lead = lead_q;
    assign lag  = lag_q;
endmodule

// File: rtl/phase_sweep_ctrl.sv
// Sweeps the differential phase code of a lead/lag clock pair around a
// fixed common-mode code, with settle/dwell per point and a measure strobe.
module phase_sweep_ctrl
    import phase_sweep_pkg::*;
#(
    parameter int N_PH  = 7,
    parameter int CNT_W = 16
) (
    input logic         clk,
    input logic         rstn,
    phase_sweep_if.slave sif
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] pt_q, pt_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] settle_q, settle_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [N_PH-1:0]  cm_q, cm_d;
    logic [N_PH-1:0]  step_q, step_d;
    logic [N_PH-1:0]  diff_q, diff_d;
    logic             busy_q, busy_d;
    logic             stb_q, stb_d;
    logic             done_q, done_d;
    logic             map_en;
    logic [CNT_W-1:0] dwell_in;
    logic [N_PH-1:0]  lead, lag;

    assign dwell_in = (sif.dwell == '0) ? ONE : sif.dwell;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pt_d     = pt_q;
        last_d   = last_q;
        settle_d = settle_q;
        dwell_d  = dwell_q;
        cm_d     = cm_q;
        step_d   = step_q;
        diff_d   = diff_q;
        map_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sif.start) begin
                    cm_d     = sif.cm_code;
                    step_d   = sif.diff_step;
                    settle_d = sif.settle;
                    dwell_d  = dwell_in;
                    last_d   = (sif.n_pts == '0) ? '0 : sif.n_pts - ONE;
                    diff_d   = sif.diff_start;
                    pt_d     = '0;
                    map_en   = 1'b1;
                    if (sif.settle != '0) begin
                        state_d = SETTLE;
                        cnt_d   = sif.settle;
                    end else begin
                        state_d = DWELL;
                        cnt_d   = dwell_in;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == ONE) begin
                    state_d = DWELL;
                    cnt_d   = dwell_q;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            DWELL: begin
                if (cnt_q != ONE) begin
                    cnt_d = cnt_q - ONE;
                end else if (pt_q == last_q) begin
                    state_d = FINISH;
                end else begin
                    diff_d = diff_q + step_q;
                    pt_d   = pt_q + ONE;
                    map_en = 1'b1;
                    if (settle_q != '0) begin
                        state_d = SETTLE;
                        cnt_d   = settle_q;
                    end else begin
                        state_d = DWELL;
                        cnt_d   = dwell_q;
                    end
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // abort overrides any point advance computed above
        if (state_q != IDLE && sif.abort) begin
            state_d = IDLE;
            cnt_d   = cnt_q;
            pt_d    = pt_q;
            diff_d  = diff_q;
            map_en  = 1'b0;
        end
        busy_d = (state_d != IDLE);
        stb_d  = (state_d == DWELL) && (cnt_d == ONE);
        done_d = (state_d == FINISH);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pt_q     <= '0;
            last_q   <= '0;
            settle_q <= '0;
            dwell_q  <= '0;
            cm_q     <= '0;
            step_q   <= '0;
            diff_q   <= '0;
            busy_q   <= 1'b0;
            stb_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pt_q     <= pt_d;
            last_q   <= last_d;
            settle_q <= settle_d;
            dwell_q  <= dwell_d;
            cm_q     <= cm_d;
            step_q   <= step_d;
            diff_q   <= diff_d;
            busy_q   <= busy_d;
            stb_q    <= stb_d;
            done_q   <= done_d;
        end
    end

    phase_pair_map #(.N_PH(N_PH)) u_map (
        .clk  (clk),
        .rstn (rstn),
        .en   (map_en),
        .cm   (cm_d),
        .diff (diff_d),
        .lead (lead),
        .lag  (lag)
    );

    assign sif.lead_code = lead;
    assign sif.lag_code  = lag;
    assign sif.busy      = busy_q;
    assign sif.meas_stb  = stb_q;
    assign sif.done      = done_q;
    assign sif.pt_idx    = pt_q;
endmodule
